eab_mem_ctrl: RTL and testbench

Data-memory controller sitting directly upstream of the EAB word RAM; it is the only block that drives the RAM's address, data and write-enable.
- Accepts CPU load/store requests with RISC-V byte/half/word semantics and sign/zero extension.
- Hides the RAM's two-cycle registered read latency.
- Implements sub-word stores as read-modify-write, because the EAB has no byte enables.

---
 rtl/mem_ctrl_pkg.sv | 17 +
 rtl/byte_lane_unit.sv | 33 +++
 rtl/eab_mem_ctrl.sv | 110 +++++++++++
 tb/tb_eab_mem_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: funct3 encodings, controller states and access legality check for eab_mem_ctrl
package mem_ctrl_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, WR, RESP} state_e;

    // Illegal funct3 for the direction, or an address not aligned to the access size
    function automatic logic bad_access(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic illegal;
        illegal = we ? (f3 > F3_W) : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        return illegal || (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
    endfunction
endpackage

// File: rtl/byte_lane_unit.sv
// byte_lane_unit: load lane extract/extend and sub-word store merge for one 32-bit word
module byte_lane_unit
    import mem_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);
    logic [7:0]  lb;
    logic [15:0] lh;

    // Pick the addressed lane and extend it; sign fill is suppressed for the unsigned funct3 variants
    always_comb begin
        lb = word[{off, 3'b000} +: 8];
        lh = off[1] ? word[31:16] : word[15:0];
        load_data = funct3[1:0] == F3_B[1:0] ? {{24{lb[7] & ~funct3[2]}}, lb} :
                    funct3[1:0] == F3_H[1:0] ? {{16{lh[15] & ~funct3[2]}}, lh} : word;
    end

    // Overlay the right-aligned store data onto the addressed lanes of the old word
    always_comb begin
        store_word = word;
        if (funct3[1:0] == F3_B[1:0])
            store_word[{off, 3'b000} +: 8] = wdata[7:0];
        else if (funct3[1:0] == F3_H[1:0])
            store_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
        else
            store_word = wdata;
    end
endmodule

// File: rtl/eab_mem_ctrl.sv
// eab_mem_ctrl: load/store controller for the EAB word RAM with read-modify-write sub-word stores
module eab_mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q
);
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [1:0]            off_q, off_d;
    logic [2:0]            f3_q, f3_d;
    logic                  we_q, we_d, err_q, err_d;
    logic [DATA_WIDTH-1:0] data_q, data_d, rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] load_data, store_word;
    logic                  unused_addr;

    // Address bits above the RAM range wrap silently
    assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];

    byte_lane_unit u_lanes (
        .funct3     (f3_q),
        .off        (off_q),
        .word       (ram_q),
        .wdata      (data_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // State and captured request registers; reset aborts any operation before its write cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            waddr_q <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            err_q   <= err_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
        end
    end

    // Sequencing: capture on accept, wait out the two-cycle RAM read, merge or extract, write, respond
    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        off_d   = off_q;
        f3_d    = f3_q;
        we_d    = we_q;
        err_d   = err_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (req_valid) begin
                waddr_d = req_addr[ADDR_WIDTH+1:2];
                off_d   = req_addr[1:0];
                f3_d    = req_funct3;
                we_d    = req_we;
                err_d   = bad_access(req_we, req_funct3, req_addr[1:0]);
                data_d  = req_wdata;
                rdata_d = '0;
                state_d = err_d ? RESP : (req_we && req_funct3 == F3_W) ? WR : RD0;
            end
            RD0: state_d = RD1;
            RD1: state_d = RD2;
            RD2: begin
                data_d  = we_q ? store_word : data_q;
                rdata_d = we_q ? rdata_q : load_data;
                state_d = we_q ? WR : RESP;
            end
            WR:   state_d = RESP;
            RESP: state_d = resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready   = state_q == IDLE;
    assign resp_valid  = state_q == RESP;
    assign ram_we      = state_q == WR;
    assign ram_address = waddr_q;
    assign ram_data    = data_q;
    assign resp_rdata  = rdata_q;
    assign resp_err    = err_q;
endmodule

// File: tb/tb_eab_mem_ctrl.sv
// tb_eab_mem_ctrl: scoreboard bench for eab_mem_ctrl against a byte-addressed memory model
module tb_eab_mem_ctrl;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = 3'd0;
    logic [31:0]   req_addr = 32'd0;
    logic [31:0]   req_wdata = 32'd0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] ram_address;
    logic [31:0]   ram_data;
    logic          ram_we;
    logic [31:0]   ram_q = 32'd0;

    eab_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_we      (ram_we),
        .ram_q       (ram_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   rdata;
        logic          err;
        int            lat;
        int            acc;
        int            nwr;
        logic [AW-1:0] waddr;
        logic [31:0]   wword;
    } exp_t;

    logic [7:0]  mb [1024];
    logic [31:0] ram [256];
    logic [31:0] q1 = 32'd0;
    logic        init_ram = 1'b1;
    exp_t        sbq [$];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // EAB RAM: registered address, one more register on q, so q is valid two cycles after the address
    always @(posedge clk) begin
        if (init_ram) begin
            for (int i = 0; i < 256; i++) ram[i] <= {mb[4*i+3], mb[4*i+2], mb[4*i+1], mb[4*i]};
        end else if (ram_we) begin
            ram[ram_address] <= ram_data;
        end
        q1    <= ram[ram_address];
        ram_q <= q1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: DUT did not respond within the cycle bound", name);
    endtask

    // Reference: byte-addressed memory, little-endian, with RISC-V load/store rules
    task automatic predict(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input bit commit, output exp_t e);
        int a, base, k, n;
        a = int'(addr[9:0]);
        k = a % 4;
        base = a - k;
        n = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
        e.err = (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6)) || (a % n != 0);
        e.rdata = 32'd0;
        e.nwr = 0;
        e.waddr = addr[9:2];
        e.wword = 32'd0;
        e.acc = 0;
        e.lat = 1;
        if (!e.err && !we) begin
            for (int i = 0; i < n; i++) e.rdata[8*i +: 8] = mb[a+i];
            if (!f3[2]) for (int i = 8*n; i < 32; i++) e.rdata[i] = e.rdata[8*n-1];
            e.lat = 4;
        end else if (!e.err) begin
            for (int j = 0; j < 4; j++) e.wword[8*j +: 8] = mb[base+j];
            for (int j = 0; j < n; j++) e.wword[8*(k+j) +: 8] = wd[8*j +: 8];
            if (commit) for (int j = 0; j < 4; j++) mb[base+j] = e.wword[8*j +: 8];
            e.nwr = 1;
            e.lat = n == 4 ? 2 : 5;
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit commit);
        exp_t e;
        int n;
        n = 0;
        req_valid = 1'b1;
        req_we = we;
        req_funct3 = f3;
        req_addr = addr;
        req_wdata = wd;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            timeout("accept");
            req_valid = 1'b0;
        end else begin
            predict(we, f3, addr, wd, commit, e);
            @(posedge clk);
            #1;
            e.acc = cyc;
            sbq.push_back(e);
            req_valid = 1'b0;
        end
    endtask

    task automatic drain(input bit rnd);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            resp_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            n++;
        end
        if (sbq.size() != 0) begin
            timeout("response");
            sbq.delete();
        end
        resp_ready = 1'b1;
    endtask

    task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        issue(we, f3, addr, wd, 1'b1);
        drain(1'b0);
    endtask

    // Monitor: write-port checks, first-valid latency, hold stability, and pop on handshake
    initial begin
        logic        seen;
        logic [31:0] prev_rd;
        logic        prev_err;
        int          wcnt;
        seen = 1'b0;
        prev_rd = 32'd0;
        prev_err = 1'b0;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
                wcnt = 0;
            end else begin
                if (ram_we) begin
                    wcnt++;
                    if (sbq.size() == 0) begin
                        check("ram_we_unexpected", 32'd1, 32'd0);
                    end else begin
                        check("ram_address", 32'(ram_address), 32'(sbq[0].waddr));
                        check("ram_data", ram_data, sbq[0].wword);
                    end
                end
                if (resp_valid) begin
                    if (sbq.size() == 0) begin
                        check("resp_unexpected", 32'd1, 32'd0);
                    end else begin
                        if (!seen) check("latency", 32'(cyc - sbq[0].acc + 1), 32'(sbq[0].lat));
                        else begin
                            check("stable_rdata", resp_rdata, prev_rd);
                            check("stable_err", 32'(resp_err), 32'(prev_err));
                        end
                        seen = 1'b1;
                        prev_rd = resp_rdata;
                        prev_err = resp_err;
                        if (resp_ready) begin
                            check("resp_rdata", resp_rdata, sbq[0].rdata);
                            check("resp_err", 32'(resp_err), 32'(sbq[0].err));
                            check("write_count", 32'(wcnt), 32'(sbq[0].nwr));
                            void'(sbq.pop_front());
                            seen = 1'b0;
                            wcnt = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
        check({tag, "_ram_address"}, 32'(ram_address), 32'd0);
        check({tag, "_ram_data"}, ram_data, 32'd0);
    endtask

    initial begin
        int n;
        logic [31:0] a;
        for (int i = 0; i < 1024; i++) mb[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        init_ram = 1'b0;
        rst_n = 1'b1;

        op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        check("sw_word4", ram[4], 32'hDEADBEEF);
        op(1'b0, 3'b010, 32'h10, 32'h0);

        op(1'b1, 3'b000, 32'h12, 32'h000000AA);
        check("sb_word4", ram[4], 32'hDEAABEEF);
        op(1'b0, 3'b000, 32'h12, 32'h0);
        op(1'b0, 3'b100, 32'h12, 32'h0);

        op(1'b1, 3'b001, 32'h12, 32'h00001234);
        check("sh_word4", ram[4], 32'h1234BEEF);
        op(1'b0, 3'b001, 32'h10, 32'h0);
        op(1'b0, 3'b101, 32'h10, 32'h0);

        op(1'b0, 3'b010, 32'h11, 32'h0);
        op(1'b1, 3'b001, 32'h13, 32'hFFFFFFFF);
        check("err_word4", ram[4], 32'h1234BEEF);

        issue(1'b1, 3'b000, 32'h12, 32'h00000055, 1'b0);
        n = 0;
        while (!ram_we && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ram_we) timeout("reach_wr");
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_wr_reset");
        sbq.delete();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_word4", ram[4], 32'h1234BEEF);

        issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
        resp_ready = 1'b0;
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid) timeout("stall_resp");
        req_valid = 1'b1;
        req_we = 1'b0;
        req_funct3 = 3'b101;
        req_addr = 32'h12;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("ready_while_stalled", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        @(negedge clk);
        check("ready_in_handshake_cycle", 32'(req_ready), 32'd0);
        issue(1'b0, 3'b101, 32'h12, 32'h0, 1'b1);
        drain(1'b0);

        for (int i = 0; i < 400; i++) begin
            a = $urandom_range(0, 1) != 0 ? 32'($urandom) : ((32'($urandom) & 32'hFFFF_FC00) | 32'($urandom_range(0, 63)));
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, 32'($urandom), 1'b1);
            drain(1'b1);
        end

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 256; i++)
            check("final_ram", ram[i], {mb[4*i+3], mb[4*i+2], mb[4*i+1], mb[4*i]});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
